// File: rtl/div_unit_pkg.sv
// Shared constants for the multi-cycle integer divider: FSM state codes,
// result-ready flag values and start/stop request values.
package div_unit_pkg;

  // Divider FSM state codes
  localparam logic [1:0] DIV_FREE    = 2'b00;
  localparam logic [1:0] DIV_BY_ZERO = 2'b01;
  localparam logic [1:0] DIV_ON      = 2'b10;
  localparam logic [1:0] DIV_END     = 2'b11;

  // Value of ready_o when a result is / is not available
  localparam logic DIV_RESULT_READY     = 1'b1;
  localparam logic DIV_RESULT_NOT_READY = 1'b0;

  // Value of start_i for a division request / no request
  localparam logic DIV_START = 1'b1;
  localparam logic DIV_STOP  = 1'b0;

endpackage

// File: rtl/div_unit.sv
// Radix-2 restoring divider, one quotient bit per clock. Signed operands are
// divided as magnitudes and the signs are reapplied on the final edge.
// result_o = {remainder, quotient}; busy_o stalls EX while a division runs.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic               annul_i,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o,
  output logic               busy_o
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [1:0]       state_reg;
  logic [CW-1:0]    counter_reg;
  // Dividend bits shift out of the top while quotient bits shift in at the bottom
  logic [WIDTH-1:0] dq_reg;
  logic [WIDTH-1:0] rem_reg;
  logic [WIDTH-1:0] divisor_reg;
  logic             neg_quot_reg;
  logic             neg_rem_reg;

  logic [WIDTH-1:0] mag1;
  logic [WIDTH-1:0] mag2;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] quot_fix;
  logic [WIDTH-1:0] rem_fix;

  // Operand magnitudes, one restoring step, and final sign correction.
  // The partial remainder is always below the divisor, so the shifted value
  // is below twice the divisor and the WIDTH+1-bit difference's MSB is its sign.
  always_comb begin
    mag1     = (signed_div_i && opdata1_i[WIDTH-1]) ? (~opdata1_i + 1'b1) : opdata1_i;
    mag2     = (signed_div_i && opdata2_i[WIDTH-1]) ? (~opdata2_i + 1'b1) : opdata2_i;
    shifted  = {rem_reg, dq_reg[WIDTH-1]};
    diff     = shifted - {1'b0, divisor_reg};
    quot_fix = neg_quot_reg ? (~dq_reg + 1'b1) : dq_reg;
    rem_fix  = neg_rem_reg  ? (~rem_reg + 1'b1) : rem_reg;
  end

  // Stall request decodes the state register directly
  assign busy_o = (state_reg == DIV_BY_ZERO) || (state_reg == DIV_ON);

  // Divider FSM and datapath; annul_i overrides everything outside FREE
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= DIV_FREE;
      counter_reg  <= '0;
      dq_reg       <= '0;
      rem_reg      <= '0;
      divisor_reg  <= '0;
      neg_quot_reg <= 1'b0;
      neg_rem_reg  <= 1'b0;
      result_o     <= '0;
      ready_o      <= DIV_RESULT_NOT_READY;
    end else begin
      case (state_reg)
        DIV_FREE: begin
          result_o <= '0;
          ready_o  <= DIV_RESULT_NOT_READY;
          if (start_i == DIV_START && !annul_i) begin
            state_reg    <= (opdata2_i == '0) ? DIV_BY_ZERO : DIV_ON;
            counter_reg  <= '0;
            dq_reg       <= mag1;
            rem_reg      <= '0;
            divisor_reg  <= mag2;
            neg_quot_reg <= signed_div_i & (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
            neg_rem_reg  <= signed_div_i & opdata1_i[WIDTH-1];
          end
        end

        DIV_BY_ZERO: begin
          result_o <= '0;
          if (annul_i) begin
            state_reg <= DIV_FREE;
            ready_o   <= DIV_RESULT_NOT_READY;
          end else begin
            state_reg <= DIV_END;
            ready_o   <= DIV_RESULT_READY;
          end
        end

        DIV_ON: begin
          if (annul_i) begin
            state_reg <= DIV_FREE;
            result_o  <= '0;
            ready_o   <= DIV_RESULT_NOT_READY;
          end else if (counter_reg == CW'(WIDTH)) begin
            state_reg <= DIV_END;
            result_o  <= {rem_fix, quot_fix};
            ready_o   <= DIV_RESULT_READY;
          end else begin
            // Keep the difference when non-negative, otherwise restore
            dq_reg      <= {dq_reg[WIDTH-2:0], ~diff[WIDTH]};
            rem_reg     <= diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
            counter_reg <= counter_reg + 1'b1;
          end
        end

        DIV_END: begin
          if (annul_i || start_i == DIV_STOP) begin
            state_reg <= DIV_FREE;
            result_o  <= '0;
            ready_o   <= DIV_RESULT_NOT_READY;
          end
        end

        default: begin
          state_reg <= DIV_FREE;
          result_o  <= '0;
          ready_o   <= DIV_RESULT_NOT_READY;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Testbench for div_unit: a cycle-level reference model of the 32-bit
// instance checked every cycle, plus directed vectors with literal results,
// and a WIDTH=8 instance exercised with a directed signed vector.
module tb_div_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic        annul;
  logic        sgn;
  logic [31:0] op1;
  logic [31:0] op2;
  logic [63:0] result;
  logic        ready;
  logic        busy;

  logic        start8;
  logic        annul8;
  logic        sgn8;
  logic [7:0]  op1_8;
  logic [7:0]  op2_8;
  logic [15:0] result8;
  logic        ready8;
  logic        busy8;

  int checks_total  = 0;
  int checks_passed = 0;
  bit compare_en    = 0;

  div_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start_i(start), .annul_i(annul), .signed_div_i(sgn),
    .opdata1_i(op1), .opdata2_i(op2), .result_o(result), .ready_o(ready), .busy_o(busy)
  );

  div_unit #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start_i(start8), .annul_i(annul8), .signed_div_i(sgn8),
    .opdata1_i(op1_8), .opdata2_i(op2_8), .result_o(result8), .ready_o(ready8), .busy_o(busy8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks_total++;
    if (act === exp) checks_passed++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Reference quotient/remainder by plain integer arithmetic (truncating
  // division, remainder takes the dividend's sign); divide by zero gives 0.
  function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                          input logic s, input int w);
    logic [63:0] mask;
    longint sa, sb, q, r;
    mask = (64'd1 << w) - 64'd1;
    sa = longint'(a) & longint'(mask);
    sb = longint'(b) & longint'(mask);
    if (sb == 0) return 64'd0;
    if (s && a[w-1]) sa = sa - (longint'(1) << w);
    if (s && b[w-1]) sb = sb - (longint'(1) << w);
    q = sa / sb;
    r = sa % sb;
    return ((64'(r) & mask) << w) | (64'(q) & mask);
  endfunction

  // Transaction-level model of the 32-bit instance: idle / busy countdown / done
  int          m_phase;
  int          m_left;
  logic [63:0] m_pend;
  logic [63:0] m_res;
  logic        m_ready;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_phase <= 0;
      m_left  <= 0;
      m_pend  <= 64'd0;
      m_res   <= 64'd0;
      m_ready <= 1'b0;
    end else if (m_phase == 0) begin
      m_res   <= 64'd0;
      m_ready <= 1'b0;
      if (start && !annul) begin
        m_pend  <= ref_div(op1, op2, sgn, 32);
        m_left  <= (op2 == 32'd0) ? 1 : 33;
        m_phase <= 1;
      end
    end else if (m_phase == 1) begin
      if (annul) begin
        m_phase <= 0;
        m_res   <= 64'd0;
        m_ready <= 1'b0;
      end else begin
        m_left <= m_left - 1;
        if (m_left == 1) begin
          m_phase <= 2;
          m_res   <= m_pend;
          m_ready <= 1'b1;
        end
      end
    end else begin
      if (annul || !start) begin
        m_phase <= 0;
        m_res   <= 64'd0;
        m_ready <= 1'b0;
      end
    end
  end

  // Every-cycle comparison of the 32-bit instance against the model
  always @(negedge clk) begin
    if (compare_en) begin
      check("model_busy",   64'(busy),  64'(m_phase == 1));
      check("model_ready",  64'(ready), 64'(m_ready));
      check("model_result", result,     m_res);
    end
  end

  // One division with start dropped after acceptance; checks latency and result
  task automatic run_div(input string name, input logic [31:0] a, input logic [31:0] b,
                         input logic s, input logic [63:0] exp_res, input int exp_lat);
    int n;
    @(negedge clk);
    start = 1'b1; op1 = a; op2 = b; sgn = s;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      start = 1'b0;
    end while (!ready && n < 200);
    check({name, "_latency"}, 64'(n), 64'(exp_lat));
    check({name, "_result"}, result, exp_res);
    $display("div %s: %h / %h signed=%0d -> %h in %0d cycles", name, a, b, s, result, n);
  endtask

  initial begin
    int n;
    rst = 1'b0; start = 1'b0; annul = 1'b0; sgn = 1'b0; op1 = '0; op2 = '0;
    start8 = 1'b0; annul8 = 1'b0; sgn8 = 1'b0; op1_8 = '0; op2_8 = '0;
    @(posedge clk);
    compare_en = 1;
    repeat (2) @(negedge clk);
    check("reset_busy",   64'(busy),  64'd0);
    check("reset_ready",  64'(ready), 64'd0);
    check("reset_result", result,     64'd0);
    rst = 1'b1;

    // Basic vectors
    run_div("u100_7",  32'd100,       32'd7,         1'b0, 64'h00000002_0000000E, 34);
    run_div("s-7_2",   32'hFFFFFFF9,  32'd2,         1'b1, 64'hFFFFFFFF_FFFFFFFD, 34);
    run_div("s7_-2",   32'd7,         32'hFFFFFFFE,  1'b1, 64'h00000001_FFFFFFFD, 34);
    run_div("smin_-1", 32'h80000000,  32'hFFFFFFFF,  1'b1, 64'h00000000_80000000, 34);
    run_div("umax_1",  32'hFFFFFFFF,  32'd1,         1'b0, 64'h00000000_FFFFFFFF, 34);
    run_div("div0",    32'd12345,     32'd0,         1'b1, 64'h0, 2);

    // Annul in cycle 10, then a fresh start in cycle 12
    @(negedge clk);
    start = 1'b1; op1 = 32'd100; op2 = 32'd7; sgn = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      start = 1'b0;
      if (n == 10) annul = 1'b1;
    end while (n < 11);
    annul = 1'b0;
    check("annul_busy",  64'(busy),  64'd0);
    check("annul_ready", 64'(ready), 64'd0);
    $display("div annul: 100 / 7 cancelled in cycle 10");
    run_div("after_annul", 32'd1000, 32'd33, 1'b0, 64'h0000000A_0000001E, 34);

    // start held past ready, operands changed while dividing
    @(negedge clk);
    start = 1'b1; op1 = 32'd200; op2 = 32'd9; sgn = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 5) begin op1 = 32'hDEADBEEF; op2 = 32'd0; sgn = 1'b1; end
    end while (!ready && n < 200);
    check("hold_latency", 64'(n), 64'd34);
    check("hold_result", result, 64'h00000002_00000016);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_ready_stable",  64'(ready), 64'd1);
      check("hold_result_stable", result, 64'h00000002_00000016);
    end
    start = 1'b0;
    @(negedge clk);
    check("release_ready",  64'(ready), 64'd0);
    check("release_result", result, 64'd0);
    $display("div hold: 200 / 9 held 5 cycles then released");

    // Asynchronous reset mid-division
    @(negedge clk);
    start = 1'b1; op1 = 32'd100; op2 = 32'd7; sgn = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    check("pre_reset_busy", 64'(busy), 64'd1);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("async_reset_busy",   64'(busy),  64'd0);
    check("async_reset_ready",  64'(ready), 64'd0);
    check("async_reset_result", result,     64'd0);
    $display("div reset: asynchronous reset during division");
    @(negedge clk);
    rst = 1'b1;
    run_div("post_reset", 32'd100, 32'd7, 1'b0, 64'h00000002_0000000E, 34);

    // WIDTH=8 instance: signed -128 / 3
    @(negedge clk);
    start8 = 1'b1; op1_8 = 8'h80; op2_8 = 8'd3; sgn8 = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      start8 = 1'b0;
      if (n == 1) check("w8_busy_cycle1", 64'(busy8), 64'd1);
    end while (!ready8 && n < 200);
    check("w8_latency", 64'(n), 64'd10);
    check("w8_result", 64'(result8), 64'h0000_0000_0000_FED6);
    check("w8_busy_done", 64'(busy8), 64'd0);
    $display("div w8: 80 / 03 signed=1 -> %h in %0d cycles", result8, n);

    repeat (2) @(negedge clk);
    compare_en = 0;
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule

// File: doc/div_unit.md
# div_unit

Parametrised multi-cycle integer divider for the execute stage, the next step after the single-cycle HI/LO datapath: DIV/DIVU results land in the HI/LO register through the existing EX→MEM→WB hilo path. Performs radix-2 restoring division, one quotient bit per clock. Supports signed and unsigned modes, operand width WIDTH, divide-by-zero detection, and annulment on pipeline flush. EX holds the pipeline (stall request) while `busy_o` is high.

## Interface
- WIDTH, 32, operand width in bits; ≥ 4.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- start_i  in  1  request a division; sampled only in FREE.
- annul_i  in  1  cancel the current or pending operation (flush).
- signed_div_i  in  1  1 = two's-complement operands, 0 = unsigned.
- opdata1_i  in  WIDTH  dividend.
- opdata2_i  in  WIDTH  divisor.
- result_o  out  2*WIDTH  {remainder, quotient}; upper half goes to HI, lower half to LO.
- ready_o  out  1  result_o is valid.
- busy_o  out  1  stall request to pipeline control; high in BYZERO and ON.

## Operation
- States (encoding constants in defines.v): FREE, BYZERO, ON, END.
- FREE: if start_i=1 and annul_i=0, latch operands and mode.
  - Divisor = 0 → BYZERO.
  - Otherwise → ON with counter=0.
  - Signed mode: latch absolute values. Record the quotient sign (sign1 XOR sign2) and the remainder sign (sign1).
- BYZERO: next edge → END with result 0.
- ON: each edge shifts the partial remainder left by one and brings in the next dividend bit (MSB first), then subtracts the divisor. A non-negative difference sets the quotient bit to 1 and keeps the difference; a negative one sets it to 0 and restores the remainder. Counter increments.
  - At the edge where counter == WIDTH, apply sign correction (two's-complement negate where recorded), register result_o, go to END.
- END: ready_o=1, result_o held. Stays in END while start_i=1. start_i=0 → FREE, with ready_o=0 and result_o=0 on that edge.
- annul_i=1 in BYZERO, ON or END → FREE next edge, with result_o=0 and ready_o=0. annul_i has priority over start_i in every state.
- Operand or mode changes after acceptance are ignored. start_i while not in FREE is ignored.
- Arithmetic:
  - Partial remainder is WIDTH+1 bits, so the subtraction sign is explicit.
  - Magnitudes are treated as WIDTH-bit unsigned, so |−2^(WIDTH−1)| is exact.
  - Signed −2^(WIDTH−1) / −1 yields quotient 2^(WIDTH−1) (wraps to most-negative), remainder 0. No trap.
  - Divide by zero: quotient 0, remainder 0.

## Timing
- Reset state: FREE, result_o=0, ready_o=0, busy_o=0, counter=0, internal registers 0.
- Reset asserted mid-operation returns to FREE immediately. No partial result is visible.
- All outputs are registered; busy_o decodes the state register directly.
- Normal latency:
  - start_i presented in cycle 0.
  - Cycle 1 onward: busy_o=1.
  - Cycle WIDTH+2: ready_o=1 and busy_o=0 (cycle 34 for WIDTH=32).
- Divide by zero: busy_o=1 in cycle 1, ready_o=1 in cycle 2.
- Back-to-back operations: after ready_o, start_i must drop for at least one cycle. The next start is accepted in the FREE cycle that follows.

## Structure
- defines.v gains:
  - state codes DivFree, DivByZero, DivOn, DivEnd;
  - DivResultReady / DivResultNotReady;
  - DivStart / DivStop.
- Single module. The iteration step is one WIDTH+1-bit subtract inline, so no sub-module is warranted.
- Pipeline control consumes busy_o for the stall. EX muxes result_o into hi_o/lo_o when ready_o=1.

## Test plan
- Unsigned 100 / 7, WIDTH=32 → ready_o in cycle 34, result_o = 0x00000002_0000000E, busy_o high in cycles 1–33.
- Signed −7 / 2 → quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. Signed 7 / −2 → quotient 0xFFFFFFFD, remainder 0x00000001.
- Signed 0x80000000 / 0xFFFFFFFF → result_o = 0x00000000_80000000. Unsigned 0xFFFFFFFF / 1 → quotient 0xFFFFFFFF, remainder 0.
- Divisor 0 → ready_o in cycle 2, result_o = 0. annul_i pulsed in cycle 10 of a normal division → FREE in cycle 11, ready_o never rises. A fresh start in cycle 12 completes correctly.
- start_i held high 5 cycles past ready_o → result stable and ready_o high throughout. start_i low → ready_o=0 and result_o=0 next cycle. Operands changed during ON → result unaffected.
- rst pulled low asynchronously mid-ON (between edges) → outputs 0 immediately. After release, a new 100 / 7 completes with the normal latency.
- WIDTH=8 instance: signed −128 / 3 → quotient 0xD6, remainder 0xFE, ready_o in cycle 10.
